// File: rtl/boron_dec_keymix_stage.sv
// boron_dec_keymix_stage
//
// Decryption key-mix stage. Each accepted round input is XORed with its round
// key and run through the inverse XOR layer. The result goes into a 2-entry
// FIFO that feeds the downstream inverse round-permutation stage.
//
// Ports
//   clk_i        rising-edge clock
//   rst_i        asynchronous active-high reset
//   in_valid_i   data_i/rkey_i hold a valid round input
//   in_ready_o   stage can accept an input this cycle (count != 2)
//   data_i       64-bit round state, word0=[15:0] .. word3=[63:48]
//   rkey_i       64-bit round key
//   out_valid_o  head entry is valid (count != 0)
//   out_ready_i  downstream accepts data_o this cycle
//   data_o       head entry, same word ordering as data_i
//   round_o      round tag of the head entry   (BORON_DEC_ROUND_TAG_EN only)
//   last_o       head entry is round 24        (BORON_DEC_ROUND_TAG_EN only)
//
// Optional feature macro: BORON_DEC_ROUND_TAG_EN
//   When defined, a 5-bit round counter tags every accepted entry. The counter
//   counts 0..24 and then wraps.

module boron_dec_keymix_stage (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [63:0] data_i,
    input  logic [63:0] rkey_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [63:0] data_o
`ifdef BORON_DEC_ROUND_TAG_EN
    ,
    output logic [4:0]  round_o,
    output logic        last_o
`endif
);

    logic [63:0] t;
    logic [63:0] mix;

    logic [63:0] mem_q [2];
    logic        wr_ptr_q;
    logic        rd_ptr_q;
    logic [1:0]  count_q;
    logic [1:0]  count_d;

    logic        push;
    logic        pop;

    // Key add followed by the inverse XOR layer. Every term comes from t,
    // not from partially mixed words.
    always_comb begin
        t   = data_i ^ rkey_i;
        mix = {t[63:48] ^ t[15:0],
               t[47:32] ^ t[63:48],
               t[31:16],
               t[15:0]  ^ t[31:16]};
    end

    // Handshakes use only the registered count, so out_ready_i has no
    // combinational path to in_ready_o.
    assign push = in_valid_i && (count_q != 2'd2);
    assign pop  = out_ready_i && (count_q != 2'd0);

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (pop && !push) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q[0] <= 64'd0;
            mem_q[1] <= 64'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= mix;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

    assign out_valid_o = (count_q != 2'd0);
    assign in_ready_o  = (count_q != 2'd2);
    assign data_o      = mem_q[rd_ptr_q];

`ifdef BORON_DEC_ROUND_TAG_EN
    logic [4:0] round_q;
    logic [4:0] tag_q [2];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            round_q  <= 5'd0;
            tag_q[0] <= 5'd0;
            tag_q[1] <= 5'd0;
        end else if (push) begin
            tag_q[wr_ptr_q] <= round_q;
            round_q         <= (round_q == 5'd24) ? 5'd0 : round_q + 5'd1;
        end
    end

    assign round_o = tag_q[rd_ptr_q];
    assign last_o  = (tag_q[rd_ptr_q] == 5'd24);
`endif

endmodule

// File: tb/tb_boron_dec_keymix_stage.sv
// Testbench for boron_dec_keymix_stage: fixed vectors, hand-written FIFO corner
// sequences and randomized traffic compared against a queue-based model.

module tb_boron_dec_keymix_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] data;
    logic [63:0] rkey;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] data_out;
`ifdef BORON_DEC_ROUND_TAG_EN
    logic [4:0]  round;
    logic        last;
`endif

    boron_dec_keymix_stage dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .data_i      (data),
        .rkey_i      (rkey),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .data_o      (data_out)
`ifdef BORON_DEC_ROUND_TAG_EN
        ,
        .round_o     (round),
        .last_o      (last)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: a queue of pending results and their round tags.
    logic [63:0] mq_data[$];
    logic [4:0]  mq_tag[$];
    int          mround = 0;

    typedef struct {
        logic [63:0] d;
        logic [63:0] k;
        logic [63:0] exp;
    } vec_t;

    vec_t tv [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Output word i is t_i ^ t_(i+1 mod 4), except word 1 which passes through.
    function automatic logic [63:0] keymix(input logic [63:0] d, input logic [63:0] k);
        logic [15:0] w [4];
        logic [15:0] m [4];
        logic [63:0] t;
        t = d ^ k;
        for (int i = 0; i < 4; i++) w[i] = t[16*i +: 16];
        for (int i = 0; i < 4; i++) m[i] = (i == 1) ? w[i] : (w[i] ^ w[(i + 1) % 4]);
        return {m[3], m[2], m[1], m[0]};
    endfunction

    task automatic model_clear();
        mq_data.delete();
        mq_tag.delete();
        mround = 0;
    endtask

    // Drive one cycle of inputs, compare registered outputs against the model,
    // clock once and update the model.
    task automatic step(input logic v, input logic [63:0] d, input logic [63:0] k,
                        input logic r);
        bit acc;
        bit popv;
        in_valid  = v;
        data      = d;
        rkey      = k;
        out_ready = r;
        chk("in_ready", {63'd0, in_ready}, {63'd0, mq_data.size() != 2});
        chk("out_valid", {63'd0, out_valid}, {63'd0, mq_data.size() != 0});
        if (mq_data.size() != 0) begin
            chk("data_o", data_out, mq_data[0]);
`ifdef BORON_DEC_ROUND_TAG_EN
            chk("round_o", {59'd0, round}, {59'd0, mq_tag[0]});
            chk("last_o", {63'd0, last}, {63'd0, mq_tag[0] == 5'd24});
`endif
        end
        acc  = v && (mq_data.size() < 2);
        popv = r && (mq_data.size() > 0);
        @(posedge clk);
        #1;
        if (popv) begin
            void'(mq_data.pop_front());
            void'(mq_tag.pop_front());
        end
        if (acc) begin
            mq_data.push_back(keymix(d, k));
            mq_tag.push_back(5'(mround));
            mround = (mround + 1) % 25;
        end
    endtask

    task automatic chk_reset_vals(input string name);
        chk({name, "_out_valid"}, {63'd0, out_valid}, 64'd0);
        chk({name, "_in_ready"}, {63'd0, in_ready}, 64'd1);
        chk({name, "_data_o"}, data_out, 64'd0);
`ifdef BORON_DEC_ROUND_TAG_EN
        chk({name, "_round_o"}, {59'd0, round}, 64'd0);
        chk({name, "_last_o"}, {63'd0, last}, 64'd0);
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        #1;
        chk_reset_vals("rst_async");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        model_clear();
    endtask

    initial begin
        int lasts_seen;
        tv[0] = '{64'h0000_0000_0000_0001, 64'h0, 64'h0001_0000_0000_0001};
        tv[1] = '{64'h1234_5678_9ABC_DEF0, 64'h0, 64'hCCC4_444C_9ABC_444C};
        tv[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
        tv[3] = '{64'h0, 64'h0000_0000_0000_FFFF, 64'hFFFF_0000_0000_FFFF};
        tv[4] = '{64'h0001_0000_0000_0000, 64'h0, 64'h0001_0001_0000_0000};
        tv[5] = '{64'h0000_0000_0001_0000, 64'h0, 64'h0000_0000_0001_0001};
        tv[6] = '{64'h0000_0001_0000_0000, 64'h0, 64'h0000_0001_0000_0000};

        // Outputs held at reset values while rst is high, even with traffic.
        rst       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        data      = 64'h1234_5678_9ABC_DEF0;
        rkey      = 64'h0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("rst_hold");
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        model_clear();
        chk_reset_vals("after_release");

        // Fixed vectors: one-cycle latency into an empty FIFO.
        for (int i = 0; i < 7; i++) begin
            step(1'b1, tv[i].d, tv[i].k, 1'b1);
            chk("tbl_valid", {63'd0, out_valid}, 64'd1);
            chk("tbl_data", data_out, tv[i].exp);
            step(1'b0, 64'd0, 64'd0, 1'b1);
        end

        // Back-pressure: A and B fill the FIFO, C is blocked, then drain in order.
        do_reset();
        step(1'b1, tv[0].d, tv[0].k, 1'b0);
        step(1'b1, tv[1].d, tv[1].k, 1'b0);
        chk("full_block", {63'd0, in_ready}, 64'd0);
        step(1'b1, tv[2].d, tv[2].k, 1'b0);
        chk("full_head_a", data_out, tv[0].exp);
        step(1'b1, tv[2].d, tv[2].k, 1'b1);
        chk("head_b", data_out, tv[1].exp);
        chk("ready_after_pop", {63'd0, in_ready}, 64'd1);
        step(1'b1, tv[2].d, tv[2].k, 1'b1);
        chk("head_c", data_out, tv[2].exp);
        step(1'b0, 64'd0, 64'd0, 1'b1);
        chk("drained", {63'd0, out_valid}, 64'd0);

        // Streaming: one result per cycle, FIFO never fills.
        for (int i = 0; i < 20; i++) begin
            chk("stream_ready", {63'd0, in_ready}, 64'd1);
            step(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
            chk("stream_valid", {63'd0, out_valid}, 64'd1);
        end
        step(1'b0, 64'd0, 64'd0, 1'b1);

        // Reset while full discards both entries; next value is output first.
        step(1'b1, 64'hAAAA_5555_AAAA_5555, 64'h1, 1'b0);
        step(1'b1, 64'h5555_AAAA_5555_AAAA, 64'h2, 1'b0);
        do_reset();
        step(1'b1, tv[1].d, tv[1].k, 1'b0);
        chk("post_rst_first", data_out, tv[1].exp);
`ifdef BORON_DEC_ROUND_TAG_EN
        chk("post_rst_round", {59'd0, round}, 64'd0);
`endif
        step(1'b0, 64'd0, 64'd0, 1'b1);

`ifdef BORON_DEC_ROUND_TAG_EN
        // 26 accepts: tags 0..24 then 0, last_o only on the 25th output.
        do_reset();
        lasts_seen = 0;
        for (int i = 0; i < 27; i++) begin
            if (out_valid && last) lasts_seen++;
            step(i < 26, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
        end
        chk("last_count", 64'(lasts_seen), 64'd1);
`endif

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom},
                 1'($urandom_range(0, 3) != 0 ? 1 : 0));
        end
        for (int i = 0; i < 3; i++) step(1'b0, 64'd0, 64'd0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/boron_dec_keymix_stage.md
BORON_DEC_KEYMIX_STAGE -- requirements
Module: boron_dec_keymix_stage

Interface
REQ-001 SHALL use one clock and an asynchronous, active-high reset: clk_i  in  1  rising-edge clock; rst_i  in  1  asynchronous active-high reset.
REQ-002 SHALL have the port in_valid_i  in  1  upstream asserts that data_i/rkey_i hold a valid round input.
REQ-003 SHALL have the port in_ready_o  out  1  stage can accept an input this cycle.
REQ-004 SHALL have the port data_i  in  64  round state (ciphertext or previous-round state); word0=[15:0] .. word3=[63:48].
REQ-005 SHALL have the port rkey_i  in  64  round key, qualified by in_valid_i together with data_i.
REQ-006 SHALL have the port out_valid_o  out  1  data_o is valid for the downstream inverse round-permutation stage.
REQ-007 SHALL have the port out_ready_i  in  1  downstream accepts data_o this cycle.
REQ-008 SHALL have the port data_o  out  64  key-mixed, inverse-XOR-layer result, same word ordering as data_i.
REQ-009 SHALL have the ports round_o  out  5  round index of the head entry, and last_o  out  1  head entry is round 24, present only when BORON_DEC_ROUND_TAG_EN is defined.

Function
REQ-010 SHALL compute t = data_i XOR rkey_i, split into t0=[15:0], t1=[31:16], t2=[47:32], t3=[63:48].
REQ-011 SHALL compute, all from t: m0 = t0^t1; m1 = t1; m2 = t2^t3; m3 = t3^t0; result = {m3,m2,m1,m0}.
REQ-012 SHALL accept an input when in_valid_i && in_ready_o at a rising edge; the result is written into a 2-entry FIFO.
REQ-013 SHALL pop the head entry when out_valid_o && out_ready_i at a rising edge.
REQ-014 SHALL drive out_valid_o = (count != 0) and data_o = head entry, registered outputs only; no combinational path from data_i to data_o.
REQ-015 SHALL drive in_ready_o = (count != 2), derived from the registered count; no combinational path from out_ready_i to in_ready_o.
REQ-016 SHALL give one-cycle latency: an input accepted at edge N into an empty FIFO shows out_valid_o=1 with its result after edge N.
REQ-017 SHALL handle simultaneous push and pop at count=1: count stays 1, the new entry becomes head, no bubble.
REQ-018 SHALL, at count=2, block pushes; a pop at count=2 lowers count to 1 and raises in_ready_o after that edge.
REQ-019 SHALL preserve order; no entry is dropped or duplicated. data_o stays stable while out_valid_o=1 and out_ready_i=0.
REQ-020 SHALL use FIFO read/write pointers (1 bit each) that wrap 1->0, and count in the range 0..2.

Reset
REQ-021 SHALL, on rst_i=1 (asynchronously), clear count, pointers and round counter; out_valid_o=0, data_o=0, in_ready_o=1, round_o=0, last_o=0.
REQ-022 SHALL discard buffered entries when reset is asserted mid-operation; the first accept after release is tagged round 0.
REQ-023 SHALL hold all outputs at their reset values while rst_i=1, regardless of in_valid_i/out_ready_i.

Configuration
REQ-024 SHALL, with BORON_DEC_ROUND_TAG_EN defined, keep a 5-bit round counter that increments on each accept and wraps 24->0; each entry stores its tag; round_o = head tag; last_o = (head tag == 24).
REQ-025 SHALL, without BORON_DEC_ROUND_TAG_EN, omit round_o, last_o, the counter and tag storage; the data path and handshake are unchanged.

Verification
REQ-026 SHALL cover: data_i=0x0000_0000_0000_0001, rkey_i=0, out_ready_i=1 -> one cycle later data_o=0x0001_0000_0000_0001, out_valid_o=1.
REQ-027 SHALL cover: data_i=0x1234_5678_9ABC_DEF0, rkey_i=0 -> data_o=0xCCC4_444C_9ABC_444C; and data_i=rkey_i=0xFFFF_FFFF_FFFF_FFFF -> data_o=0.
REQ-028 SHALL cover: out_ready_i=0, three back-to-back valid inputs A,B,C -> A and B accepted, in_ready_o=0 during C; out_ready_i=1 -> A, B, then C in order, no loss.
REQ-029 SHALL cover: streaming with in_valid_i=1 and out_ready_i=1 continuously -> one result per cycle, count never exceeds 1.
REQ-030 SHALL cover: rst_i pulse while count=2 -> out_valid_o=0 and in_ready_o=1 immediately (asynchronous); the next accepted value is output first with round_o=0.
REQ-031 SHALL cover (with BORON_DEC_ROUND_TAG_EN): 26 accepts -> round_o runs 0..24 then 0; last_o=1 only on the 25th output.
